// File: rtl/sram_like_resp_pkg.sv
// Shared bus-width constants and response types for the SRAM-like responder.
// Sits next to the pipeline bus-width definitions used by the CPU ports.
package sram_like_resp_pkg;

  localparam int unsigned SRAM_ADDR_WD = 32;
  localparam int unsigned SRAM_DATA_WD = 32;
  localparam int unsigned SRAM_STRB_WD = SRAM_DATA_WD / 8;
  localparam int unsigned RESP_WD      = SRAM_DATA_WD + 1;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } sram_size_e;

  typedef struct packed {
    logic                    wr;
    logic [SRAM_DATA_WD-1:0] data;
  } resp_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11; new bit enters at the top.
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/sram_like_resp_if.sv
// SRAM-like request/response bus between a CPU port (master) and a responder (slave).
interface sram_like_resp_if;
  import sram_like_resp_pkg::*;

  logic                    req;
  logic                    wr;
  sram_size_e              size;
  logic [SRAM_STRB_WD-1:0] wstrb;
  logic [SRAM_ADDR_WD-1:0] addr;
  logic [SRAM_DATA_WD-1:0] wdata;
  logic                    addr_ok;
  logic                    data_ok;
  logic [SRAM_DATA_WD-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// Response FIFO: synchronous, DEPTH entries, wrap-around tracked by an occupancy count.
module sram_like_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign dout  = mem_q[rptr_q];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like bus responder: issues to a 1-cycle-latency sync RAM, returns in-order responses,
// bounds outstanding requests to DEPTH and can randomly withhold handshakes from an LFSR.
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 2,
  parameter bit          STALL_EN = 1'b0,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_like_resp_if.slave         bus,
  output logic                    ram_en,
  output logic [SRAM_STRB_WD-1:0] ram_wen,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [SRAM_DATA_WD-1:0] ram_wdata,
  input  logic [SRAM_DATA_WD-1:0] ram_rdata
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            p_valid_q, p_valid_d;
  logic            p_wr_q, p_wr_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic            a_stall, d_stall;
  logic            addr_ok, data_ok, accept;
  logic            fifo_empty, fifo_full;
  resp_t           fifo_din, fifo_dout;
  logic            unused_bits;

  // addr_ok looks only at registered state, never at the request fields.
  always_comb begin
    a_stall = STALL_EN & lfsr_q[0] & lfsr_q[1];
    d_stall = STALL_EN & lfsr_q[2] & lfsr_q[3];
    addr_ok = (cnt_q < CntW'(DEPTH)) & ~a_stall;
    accept  = bus.req & addr_ok;
    data_ok = ~fifo_empty & ~d_stall;
  end

  always_comb begin
    ram_en    = accept;
    ram_wen   = (accept & bus.wr) ? bus.wstrb : '0;
    ram_addr  = bus.addr[ADDR_W+1:2];
    ram_wdata = bus.wdata;
  end

  always_comb begin
    fifo_din.wr   = p_wr_q;
    fifo_din.data = p_wr_q ? '0 : ram_rdata;
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = data_ok ? fifo_dout.data : '0;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, data_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    p_valid_d = accept;
    p_wr_d    = accept & bus.wr;
    lfsr_d    = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      p_valid_q <= 1'b0;
      p_wr_q    <= 1'b0;
      lfsr_q    <= SEED;
    end else begin
      cnt_q     <= cnt_d;
      p_valid_q <= p_valid_d;
      p_wr_q    <= p_wr_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // cnt covers capture stage plus FIFO, so a push never meets a full FIFO.
  sram_like_resp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(RESP_WD)
  ) u_resp_fifo (
    .clk  (clk),
    .reset(reset),
    .push (p_valid_q),
    .pop  (data_ok),
    .din  (fifo_din),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Byte lanes and size are applied by the CPU; the RAM sees whole words.
  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[SRAM_ADDR_WD-1:ADDR_W+2],
                         fifo_full, fifo_dout.wr};

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: a no-stall DEPTH=2 instance and a stalling DEPTH=3 instance share
// stimulus; a cycle-level reference model checks both, directed literals pin the no-stall one.
module tb_sram_like_resp;
  import sram_like_resp_pkg::*;

  localparam logic [15:0] Seed = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  always #5 clk = ~clk;

  sram_like_resp_if bus0 ();
  sram_like_resp_if bus1 ();

  assign bus0.req = req;   assign bus1.req = req;
  assign bus0.wr = wr;     assign bus1.wr = wr;
  assign bus0.size = sram_size_e'(size);
  assign bus1.size = sram_size_e'(size);
  assign bus0.wstrb = wstrb; assign bus1.wstrb = wstrb;
  assign bus0.addr = addr;   assign bus1.addr = addr;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata;

  logic        ram_en    [2];
  logic [3:0]  ram_wen   [2];
  logic [15:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];

  sram_like_resp #(.ADDR_W(16), .DEPTH(2), .STALL_EN(1'b0), .SEED(Seed)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .ram_en(ram_en[0]), .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  sram_like_resp #(.ADDR_W(16), .DEPTH(3), .STALL_EN(1'b1), .SEED(Seed)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .ram_en(ram_en[1]), .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  logic        dut_aok   [2];
  logic        dut_dok   [2];
  logic [31:0] dut_rdata [2];
  int          dut_cnt   [2];

  assign dut_aok[0] = bus0.addr_ok;  assign dut_aok[1] = bus1.addr_ok;
  assign dut_dok[0] = bus0.data_ok;  assign dut_dok[1] = bus1.data_ok;
  assign dut_rdata[0] = bus0.rdata;  assign dut_rdata[1] = bus1.rdata;
  assign dut_cnt[0] = int'(dut0.cnt_q);
  assign dut_cnt[1] = int'(dut1.cnt_q);

  function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] s, logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Synchronous RAMs, one per instance, 256 words each, 1-cycle read latency.
  bit [31:0] ram_m [512];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_en[i]) begin
        if (ram_wen[i] != 4'b0)
          ram_m[i*256 + int'(ram_addr[i][7:0])] <=
            merge(ram_m[i*256 + int'(ram_addr[i][7:0])], ram_wen[i], ram_wdata[i]);
        else
          ram_rdata[i] <= ram_m[i*256 + int'(ram_addr[i][7:0])];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: memory image plus a list of expected responses with ready cycles.
  bit [31:0]   sh [512];
  int          head_m [2] = '{0, 0};
  int          tail_m [2] = '{0, 0};
  int          rdy_m [2][16];
  logic [31:0] dat_m [2][16];
  logic [15:0] lfsr_m [2] = '{Seed, Seed};
  int          cyc_n = 0;
  int          a_low = 0;
  int          withheld = 0;

  always @(negedge clk) begin
    int n, w, dep;
    bit as_b, ds_b, aok, hr, dok, acc;
    logic [31:0] exp_rd;
    logic [15:0] l;
    for (int i = 0; i < 2; i++) begin
      dep  = (i == 0) ? 2 : 3;
      n    = tail_m[i] - head_m[i];
      as_b = (i == 1) && lfsr_m[i][0] && lfsr_m[i][1];
      ds_b = (i == 1) && lfsr_m[i][2] && lfsr_m[i][3];
      aok  = (n < dep) && !as_b;
      hr   = (n > 0) && (rdy_m[i][head_m[i] % 16] <= cyc_n);
      dok  = hr && !ds_b;
      acc  = req && aok;
      exp_rd = dok ? dat_m[i][head_m[i] % 16] : 32'd0;
      chk($sformatf("addr_ok[%0d] cyc %0d", i, cyc_n), 32'(dut_aok[i]), 32'(aok));
      chk($sformatf("data_ok[%0d] cyc %0d", i, cyc_n), 32'(dut_dok[i]), 32'(dok));
      chk($sformatf("rdata[%0d] cyc %0d", i, cyc_n), dut_rdata[i], exp_rd);
      chk($sformatf("ram_en[%0d] cyc %0d", i, cyc_n), 32'(ram_en[i]), 32'(acc));
      chk($sformatf("ram_wen[%0d] cyc %0d", i, cyc_n), 32'(ram_wen[i]),
          32'((acc && wr) ? wstrb : 4'b0));
      chk($sformatf("ram_addr[%0d] cyc %0d", i, cyc_n), 32'(ram_addr[i]), 32'(addr[17:2]));
      chk($sformatf("ram_wdata[%0d] cyc %0d", i, cyc_n), ram_wdata[i], wdata);
      chk($sformatf("cnt[%0d] cyc %0d", i, cyc_n), 32'(dut_cnt[i]), 32'(n));
      if (i == 1) begin
        if (!aok) a_low++;
        if (hr && ds_b) withheld++;
      end
      if (acc) begin
        w = i*256 + int'(addr[9:2]);
        rdy_m[i][tail_m[i] % 16] = cyc_n + 2;
        dat_m[i][tail_m[i] % 16] = wr ? 32'd0 : sh[w];
        if (wr) sh[w] = merge(sh[w], wstrb, wdata);
        tail_m[i]++;
      end
      if (dok) head_m[i]++;
      l = lfsr_m[i];
      lfsr_m[i] = (l >> 1) | (16'((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h1) << 15);
      if (reset) begin
        head_m[i] = 0;
        tail_m[i] = 0;
        lfsr_m[i] = Seed;
      end
    end
    cyc_n++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One request on the no-stall instance: hold until accepted, then wait for its response.
  task automatic op(input logic w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output logic [31:0] r, output bit ok);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    ok = 1'b0;
    r = 32'd0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (dut_aok[0]) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
    req = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #3;
        if (dut_dok[0]) begin r = dut_rdata[0]; ok = 1'b1; break; end
        cyc();
      end
      cyc();
    end
  endtask

  initial begin
    logic [31:0] r;
    bit ok, saw_low, saw_both;
    int k_acc, k_rsp, acc1, mx;

    repeat (3) cyc();
    reset = 1'b0;
    #3;
    chk("reset addr_ok", 32'(dut_aok[0]), 32'd1);
    chk("reset data_ok", 32'(dut_dok[0]), 32'd0);
    chk("reset rdata", dut_rdata[0], 32'd0);
    chk("reset ram_en", 32'(ram_en[0]), 32'd0);
    chk("reset ram_wen", 32'(ram_wen[0]), 32'd0);
    cyc();

    op(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, r, ok);
    chk("preload done", 32'(ok), 32'd1);
    chk("preload rdata", r, 32'd0);

    // Single read: issue at T, response at T+2.
    req = 1'b1; wr = 1'b0; addr = 32'h40; wstrb = 4'h0;
    #3;
    chk("read ram_en T", 32'(ram_en[0]), 32'd1);
    chk("read ram_addr T", 32'(ram_addr[0]), 32'h10);
    cyc();
    req = 1'b0;
    #3;
    chk("read data_ok T+1", 32'(dut_dok[0]), 32'd0);
    cyc();
    #3;
    chk("read data_ok T+2", 32'(dut_dok[0]), 32'd1);
    chk("read rdata T+2", dut_rdata[0], 32'hDEADBEEF);
    cyc();

    op(1'b1, 32'h40, 4'hF, 32'h11223344, r, ok);
    op(1'b1, 32'h41, 4'b0010, 32'h0000AB00, r, ok);
    chk("byte write done", 32'(ok), 32'd1);
    chk("byte write rdata", r, 32'd0);
    op(1'b0, 32'h40, 4'h0, 32'h0, r, ok);
    chk("byte merge read", r, 32'h1122AB44);

    for (int k = 0; k < 6; k++) op(1'b1, 32'hC0 + 32'(4*k), 4'hF, 32'hA5A50000 + 32'(k), r, ok);

    // Six reads with req held high against DEPTH=2.
    k_acc = 0; k_rsp = 0; saw_low = 0; saw_both = 0; mx = 0;
    wr = 1'b0;
    for (int c = 0; c < 60 && k_rsp < 6; c++) begin
      req = (k_acc < 6);
      addr = 32'hC0 + 32'(4*k_acc);
      #3;
      if (dut_dok[0]) begin
        chk($sformatf("bp rdata %0d", k_rsp), dut_rdata[0], 32'hA5A50000 + 32'(k_rsp));
        k_rsp++;
      end
      if (req && !dut_aok[0]) saw_low = 1;
      if (req && dut_aok[0] && dut_dok[0]) saw_both = 1;
      if (req && dut_aok[0]) k_acc++;
      if (dut_cnt[0] > mx) mx = dut_cnt[0];
      cyc();
    end
    req = 1'b0;
    chk("bp responses", 32'(k_rsp), 32'd6);
    chk("bp addr_ok dropped", 32'(saw_low), 32'd1);
    chk("bp accept with data_ok", 32'(saw_both), 32'd1);
    chk("bp cnt max", 32'(mx), 32'd2);
    repeat (4) cyc();

    // Reset one cycle after two accepts.
    req = 1'b1; wr = 1'b0; addr = 32'h40;
    cyc();
    addr = 32'hC0;
    cyc();
    req = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    #3;
    chk("post-reset addr_ok", 32'(dut_aok[0]), 32'd1);
    chk("post-reset data_ok", 32'(dut_dok[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #3;
      chk($sformatf("post-reset quiet %0d", k), 32'(dut_dok[0]), 32'd0);
    end
    cyc();
    op(1'b0, 32'h40, 4'h0, 32'h0, r, ok);
    chk("post-reset read", r, 32'h1122AB44);

    // Random traffic; the stalling instance must accept at least 1000 requests.
    acc1 = 0;
    for (int c = 0; c < 20000 && acc1 < 1000; c++) begin
      req   = ($urandom_range(0, 3) != 0);
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom & 32'h3FF;
      wstrb = 4'($urandom);
      wdata = $urandom;
      size  = 2'($urandom_range(0, 2));
      #3;
      if (req && dut_aok[1]) acc1++;
      cyc();
    end
    req = 1'b0;
    repeat (60) cyc();
    chk("random accepts", 32'(acc1 >= 1000), 32'd1);
    chk("stall addr_ok low seen", 32'(a_low > 0), 32'd1);
    chk("stall data_ok withheld seen", 32'(withheld > 0), 32'd1);
    chk("drained 0", 32'(tail_m[0] - head_m[0]), 32'd0);
    chk("drained 1", 32'(tail_m[1] - head_m[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
